pc_unit: RTL and testbench

//  Parametrised program-counter unit for the 54-instruction MIPS core; next generation of the plain PC register.

---
 rtl/pc_if.sv | 24 ++
 rtl/pc_unit.sv | 67 ++++++
 tb/tb_pc_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// pc_if: control inputs and PC outputs of the program-counter unit, grouped for port connection.
interface pc_if #(parameter int ADDR_W = 32);
    logic              ena;
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_target;
    logic              exc_valid;
    logic              eret;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus_step;
    logic [ADDR_W-1:0] epc_out;
    logic              pend_valid;
    logic              misalign;
    modport master (
        output ena, stall, br_taken, br_target, jmp_valid, jmp_target, exc_valid, eret,
        input  pc_out, pc_plus_step, epc_out, pend_valid, misalign
    );
    modport slave (
        input  ena, stall, br_taken, br_target, jmp_valid, jmp_target, exc_valid, eret,
        output pc_out, pc_plus_step, epc_out, pend_valid, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with prioritised next-PC selection, stall-time redirect buffer and EPC capture.
module pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h00400000,
    parameter logic [31:0] EXC_VEC   = 32'h00400004,
    parameter int          STEP      = 4
) (
    input logic clk,
    input logic rst,
    pc_if.slave bus
);
    // Enum order doubles as redirect priority, so pending/incoming compare numerically.
    typedef enum logic [1:0] {K_NONE, K_BR, K_JMP, K_ERET} kind_t;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, pt_q, pt_d, in_tgt, sel_tgt, pc_plus;
    kind_t             pk_q, pk_d, in_k, sel_k;
    logic              take_in;

    assign pc_plus = pc_q + ADDR_W'(STEP);

    always_comb begin
        in_k    = bus.eret ? K_ERET : bus.jmp_valid ? K_JMP : bus.br_taken ? K_BR : K_NONE;
        in_tgt  = bus.jmp_valid ? bus.jmp_target : bus.br_target;
        take_in = (in_k != K_NONE) && (in_k >= pk_q);
        sel_k   = take_in ? in_k : pk_q;
        sel_tgt = take_in ? in_tgt : pt_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pk_d    = pk_q;
        pt_d    = pt_q;
        if (bus.exc_valid) begin
            pc_d  = EXC_PC;
            epc_d = pc_q;
            pk_d  = K_NONE;
        end else if (!bus.stall) begin
            // eret resolves against the current EPC, not a value captured at buffering time
            pc_d = sel_k == K_ERET ? epc_q : sel_k == K_NONE ? pc_plus : sel_tgt;
            pk_d = K_NONE;
        end else if (take_in) begin
            pk_d = in_k;
            pt_d = in_tgt;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            pc_q  <= RST_PC;
            epc_q <= '0;
            pk_q  <= K_NONE;
            pt_q  <= '0;
        end else if (bus.ena) begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            pk_q  <= pk_d;
            pt_q  <= pt_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_plus_step = pc_plus;
    assign bus.epc_out      = epc_q;
    assign bus.pend_valid   = pk_q != K_NONE;
    assign bus.misalign     = pc_q[1:0] != 2'b00;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench driving a 32-bit and an 8-bit pc_unit with directed and random redirects.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_if #(.ADDR_W(32)) b32 ();
    pc_if #(.ADDR_W(8))  b8 ();

    pc_unit #(.ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    pc_unit #(.ADDR_W(8), .RESET_VEC(32'h000000FC)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] pt;
        int          pk;
    } mst_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus;
        logic [31:0] epc;
        logic        pend;
        logic        mis;
    } exp_t;

    logic [31:0] msk  [2] = '{32'hFFFFFFFF, 32'h000000FF};
    logic [31:0] rstv [2] = '{32'h00400000, 32'h000000FC};
    logic [31:0] excv [2] = '{32'h00400004, 32'h00000004};

    mst_t m [2];
    exp_t q32 [$];
    exp_t q8 [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Reference: priority rank eret=3 > jmp=2 > br=1, pending replaced only by equal/higher rank.
    function automatic mst_t mstep(mst_t s, int i, logic r, logic en, logic st, logic br, logic [31:0] bt,
                                   logic jp, logic [31:0] jt, logic x, logic er);
        mst_t        n    = s;
        int          rank = er ? 3 : jp ? 2 : br ? 1 : 0;
        logic [31:0] tgt  = (jp ? jt : bt) & msk[i];
        if (!r) begin
            n.pc = rstv[i]; n.epc = 0; n.pk = 0; n.pt = 0;
        end else if (en) begin
            if (x) begin
                n.pc = excv[i]; n.epc = s.pc; n.pk = 0;
            end else begin
                if (rank > 0 && rank >= s.pk) begin
                    n.pk = rank; n.pt = tgt;
                end
                if (!st) begin
                    n.pc = n.pk == 3 ? s.epc : n.pk > 0 ? n.pt : (s.pc + 32'd4) & msk[i];
                    n.pk = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mst_t s, int i);
        exp_t e;
        e.pc   = s.pc;
        e.plus = (s.pc + 32'd4) & msk[i];
        e.epc  = s.epc;
        e.pend = s.pk != 0;
        e.mis  = s.pc[1:0] != 2'b00;
        return e;
    endfunction

    task automatic d(logic r, logic en, logic st, logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                     logic x, logic er);
        @(posedge clk);
        #1;
        rst = r;
        b32.ena = en; b32.stall = st; b32.br_taken = br; b32.br_target = bt;
        b32.jmp_valid = jp; b32.jmp_target = jt; b32.exc_valid = x; b32.eret = er;
        b8.ena = en; b8.stall = st; b8.br_taken = br; b8.br_target = bt[7:0];
        b8.jmp_valid = jp; b8.jmp_target = jt[7:0]; b8.exc_valid = x; b8.eret = er;
        for (int i = 0; i < 2; i++) m[i] = mstep(m[i], i, r, en, st, br, bt, jp, jt, x, er);
        q32.push_back(expect_of(m[0], 0));
        q8.push_back(expect_of(m[1], 1));
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rt();
        logic [31:0] t;
        t = ($urandom % 8 == 0) ? $urandom : (32'h00400000 | ($urandom & 32'h00000FFC));
        if ($urandom % 4 == 0) t[1:0] = 2'($urandom);
        return t;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                chk("pc32", b32.pc_out, e.pc);
                chk("plus32", b32.pc_plus_step, e.plus);
                chk("epc32", b32.epc_out, e.epc);
                chk("pend32", 32'(b32.pend_valid), 32'(e.pend));
                chk("mis32", 32'(b32.misalign), 32'(e.mis));
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("pc8", 32'(b8.pc_out), e.pc);
                chk("plus8", 32'(b8.pc_plus_step), e.plus);
                chk("epc8", 32'(b8.epc_out), e.epc);
                chk("pend8", 32'(b8.pend_valid), 32'(e.pend));
                chk("mis8", 32'(b8.misalign), 32'(e.mis));
            end
        end
    end

    initial begin : driver
        m[0] = '{pc: 0, epc: 0, pt: 0, pk: 0};
        m[1] = m[0];
        b32.ena = 0; b32.stall = 0; b32.br_taken = 0; b32.br_target = 0;
        b32.jmp_valid = 0; b32.jmp_target = 0; b32.exc_valid = 0; b32.eret = 0;
        b8.ena = 0; b8.stall = 0; b8.br_taken = 0; b8.br_target = 0;
        b8.jmp_valid = 0; b8.jmp_target = 0; b8.exc_valid = 0; b8.eret = 0;
        d(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", b32.pc_out, 32'h00400000);
        chk("rst_pc8", 32'(b8.pc_out), 32'h000000FC);
        chk("rst_epc", b32.epc_out, 32'h0);
        chk("rst_mis", 32'(b32.misalign), 32'h0);
        d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("seq1_pc", b32.pc_out, 32'h00400004);
        chk("wrap_pc8", 32'(b8.pc_out), 32'h0);
        repeat (2) d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("seq3_pc", b32.pc_out, 32'h0040000C);
        d(1, 1, 1, 1, 32'h00400100, 0, 0, 0, 0);
        chk("stall_hold", b32.pc_out, 32'h0040000C);
        chk("stall_pend", 32'(b32.pend_valid), 32'h1);
        d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("br_apply", b32.pc_out, 32'h00400100);
        chk("br_pend_clr", 32'(b32.pend_valid), 32'h0);
        d(1, 1, 1, 1, 32'h00400100, 0, 0, 0, 0);
        d(1, 1, 1, 0, 0, 1, 32'h00400200, 0, 0);
        d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("jmp_over_br", b32.pc_out, 32'h00400200);
        d(1, 1, 0, 0, 0, 1, 32'h00400010, 0, 0);
        d(1, 1, 1, 1, 32'h00400300, 0, 0, 0, 0);
        d(1, 1, 1, 0, 0, 0, 0, 1, 0);
        chk("exc_pc", b32.pc_out, 32'h00400004);
        chk("exc_epc", b32.epc_out, 32'h00400010);
        chk("exc_flush", 32'(b32.pend_valid), 32'h0);
        d(1, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("eret_pc", b32.pc_out, 32'h00400010);
        d(1, 1, 1, 1, 32'h00400400, 0, 0, 0, 0);
        repeat (4) d(1, 0, 1'($urandom), 1, 32'h00400500, 0, 0, 1, 0);
        chk("ena0_pc", b32.pc_out, 32'h00400010);
        chk("ena0_epc", b32.epc_out, 32'h00400010);
        chk("ena0_pend", 32'(b32.pend_valid), 32'h1);
        chk("ena0_notz", 32'($isunknown(b32.pc_out)), 32'h0);
        d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ena_resume", b32.pc_out, 32'h00400400);
        d(1, 1, 0, 0, 0, 1, 32'h00400002, 0, 0);
        chk("mis32_jmp", 32'(b32.misalign), 32'h1);
        chk("mis8_jmp", 32'(b8.misalign), 32'h1);
        d(1, 1, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
        d(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc32", b32.pc_out, 32'h0);
        d(1, 1, 0, 0, 0, 0, 0, 1, 1);
        chk("exc_eret_pc", b32.pc_out, 32'h00400004);
        chk("exc_eret_epc", b32.epc_out, 32'h0);
        for (int k = 0; k < 400; k++)
            d($urandom % 40 != 0, $urandom % 8 != 0, $urandom % 3 == 0, $urandom % 6 == 0, rt(),
              $urandom % 6 == 0, rt(), $urandom % 12 == 0, $urandom % 8 == 0);
        repeat (3) @(posedge clk);
        #1;
        if (q32.size() != 0 || q8.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q32.size() + q8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
